// File: rtl/word_uart_serializer_pkg.sv
// Shared definitions for the debug UART word serializer: state encoding,
// default byte width and checksum byte width.
// Optional checksum byte after each word: define SERIALIZER_CHECKSUM_EN.
package debug_uart_pkg;

  localparam int NB_BYTE_DEF = 8;
  localparam int CHK_W       = NB_BYTE_DEF;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_SEND     = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_CHK_SEND = 3'd4;
  localparam logic [2:0] S_CHK_WAIT = 3'd5;

`ifdef SERIALIZER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_FETCH    = S_FETCH,
    ST_SEND     = S_SEND,
    ST_WAIT     = S_WAIT,
    ST_CHK_SEND = S_CHK_SEND,
    ST_CHK_WAIT = S_CHK_WAIT
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_FETCH = S_FETCH,
    ST_SEND  = S_SEND,
    ST_WAIT  = S_WAIT
  } state_e;
`endif

  // Byte index width; a single-byte word still gets a 1-bit index.
  function automatic int idx_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/word_uart_serializer_if.sv
// FIFO-side and UART-side handshake bundle of the word serializer.
// master: the serializer; slave: FIFO + UART environment.
interface word_uart_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NB_BYTE    = 8
);
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  o_fifo_rd_en;
  logic [NB_BYTE-1:0]    o_tx_data;
  logic                  o_tx_start;
  logic                  i_tx_done;
  logic                  o_busy;
  logic                  o_word_done;

  modport master (
    input  i_fifo_empty, i_fifo_data, i_tx_done,
    output o_fifo_rd_en, o_tx_data, o_tx_start, o_busy, o_word_done
  );

  modport slave (
    output i_fifo_empty, i_fifo_data, i_tx_done,
    input  o_fifo_rd_en, o_tx_data, o_tx_start, o_busy, o_word_done
  );
endinterface

// File: rtl/word_uart_serializer_byte_select.sv
// Picks one byte out of a word by send position; MSB_FIRST reverses order.
module word_byte_select #(
  parameter int DATA_WIDTH = 32,
  parameter int NB_BYTE    = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int IDXW       = 2
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [IDXW-1:0]       idx_i,
  output logic [NB_BYTE-1:0]    byte_o
);
  localparam int NBYTES = DATA_WIDTH / NB_BYTE;

  logic [IDXW-1:0] k;

  assign k = MSB_FIRST ? (IDXW'(NBYTES - 1) - idx_i) : idx_i;

  // Constant-index mux over all byte lanes.
  always_comb begin
    byte_o = '0;
    for (int b = 0; b < NBYTES; b++)
      if (k == IDXW'(b)) byte_o = word_i[b*NB_BYTE +: NB_BYTE];
  end
endmodule

// File: rtl/word_uart_serializer.sv
// Word-to-byte serializer between the debug TX FIFO and the UART transmitter.
// Pops a word, sends its bytes with a start/done handshake, then fetches the next.
// Optional: SERIALIZER_CHECKSUM_EN appends an XOR checksum byte per word.
module word_uart_serializer
  import debug_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NB_BYTE    = NB_BYTE_DEF,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  word_uart_serializer_if.master bus
);
  localparam int              NBYTES = DATA_WIDTH / NB_BYTE;
  localparam int              IDXW   = idx_w(NBYTES);
  localparam logic [IDXW-1:0] LAST   = IDXW'(NBYTES - 1);

  state_e                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [NB_BYTE-1:0]    tx_data_q, tx_data_d;
  logic                  word_done_q, word_done_d;
`ifdef SERIALIZER_CHECKSUM_EN
  logic [NB_BYTE-1:0]    chk_q, chk_d;
`endif

  // The byte for the upcoming SEND: from FIFO data while fetching, else next index.
  logic [DATA_WIDTH-1:0] sel_word;
  logic [IDXW-1:0]       sel_idx;
  logic [NB_BYTE-1:0]    sel_byte;

  assign sel_word = (state_q == ST_FETCH) ? bus.i_fifo_data : word_q;
  assign sel_idx  = (state_q == ST_FETCH) ? '0 : idx_q + IDXW'(1);

  word_byte_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .NB_BYTE    (NB_BYTE),
    .MSB_FIRST  (MSB_FIRST),
    .IDXW       (IDXW)
  ) u_sel (
    .word_i (sel_word),
    .idx_i  (sel_idx),
    .byte_o (sel_byte)
  );

  // Next-state logic; tx data is loaded on the edge into SEND so it is valid with start.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    tx_data_d   = tx_data_q;
    word_done_d = 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
    chk_d       = chk_q;
`endif
    case (state_q)
      ST_IDLE:  if (!bus.i_fifo_empty) state_d = ST_FETCH;
      ST_FETCH: begin
        word_d    = bus.i_fifo_data;
        idx_d     = '0;
        tx_data_d = sel_byte;
`ifdef SERIALIZER_CHECKSUM_EN
        chk_d     = '0;
`endif
        state_d   = ST_SEND;
      end
      ST_SEND: begin
`ifdef SERIALIZER_CHECKSUM_EN
        chk_d   = chk_q ^ tx_data_q;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_tx_done) begin
          if (idx_q != LAST) begin
            idx_d     = idx_q + IDXW'(1);
            tx_data_d = sel_byte;
            state_d   = ST_SEND;
          end else begin
`ifdef SERIALIZER_CHECKSUM_EN
            tx_data_d   = chk_q;
            state_d     = ST_CHK_SEND;
`else
            word_done_d = 1'b1;
            state_d     = ST_IDLE;
`endif
          end
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      ST_CHK_SEND: state_d = ST_CHK_WAIT;
      ST_CHK_WAIT: begin
        if (bus.i_tx_done) begin
          word_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      tx_data_q   <= '0;
      word_done_q <= 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      tx_data_q   <= tx_data_d;
      word_done_q <= word_done_d;
`ifdef SERIALIZER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign bus.o_fifo_rd_en = (state_q == ST_FETCH);
`ifdef SERIALIZER_CHECKSUM_EN
  assign bus.o_tx_start   = (state_q == ST_SEND) || (state_q == ST_CHK_SEND);
`else
  assign bus.o_tx_start   = (state_q == ST_SEND);
`endif
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_word_done  = word_done_q;
endmodule

// File: tb/tb_word_uart_serializer.sv
// Scoreboard bench: LSB-first and MSB-first serializers share one FIFO/UART model;
// expected byte streams are computed from words by shift arithmetic.
module tb_word_uart_serializer;
  localparam int DW = 32, NBB = 8, NB = DW / NBB;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int NEXP = NB + 1;
`else
  localparam int NEXP = NB;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  word_uart_serializer_if #(.DATA_WIDTH(DW), .NB_BYTE(NBB)) bus0 ();
  word_uart_serializer_if #(.DATA_WIDTH(DW), .NB_BYTE(NBB)) bus1 ();

  word_uart_serializer #(.DATA_WIDTH(DW), .NB_BYTE(NBB), .MSB_FIRST(1'b0))
    u_dut0 (.i_clk(clk), .i_reset(rst_n), .bus(bus0));
  word_uart_serializer #(.DATA_WIDTH(DW), .NB_BYTE(NBB), .MSB_FIRST(1'b1))
    u_dut1 (.i_clk(clk), .i_reset(rst_n), .bus(bus1));

  logic          fe = 1'b1;
  logic [DW-1:0] fd = '0;
  logic          uart_done = 1'b0, spur_done = 1'b0;

  assign bus0.i_fifo_empty = fe;
  assign bus1.i_fifo_empty = fe;
  assign bus0.i_fifo_data  = fd;
  assign bus1.i_fifo_data  = fd;
  assign bus0.i_tx_done    = uart_done | spur_done;
  assign bus1.i_tx_done    = uart_done | spur_done;

  logic [DW-1:0] fifo_q[$];
  logic [7:0]    exp0[$], exp1[$];
  int wd_pend = 0, tests = 0, fails = 0, cyc = 0, dly = 10, cnt = 0;
  int rd_count = 0, wd_count = 0, rd_cyc = 0, done_cyc = 0, byte_n = 0;
  logic [7:0] last0 = '0, last1 = '0;
  bit b2b_chk = 0, b2b_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: byte k of a word is (w >> 8k) & 0xFF; checksum is XOR of all bytes.
  task automatic push_word(input logic [DW-1:0] w);
    logic [7:0] x;
    x = '0;
    fifo_q.push_back(w);
    for (int i = 0; i < NB; i++) begin
      exp0.push_back(8'((w >> (8 * i)) & 32'hFF));
      exp1.push_back(8'((w >> (8 * (NB - 1 - i))) & 32'hFF));
      x = x ^ 8'((w >> (8 * i)) & 32'hFF);
    end
`ifdef SERIALIZER_CHECKSUM_EN
    exp0.push_back(x);
    exp1.push_back(x);
`endif
    wd_pend++;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (exp0.size() == 0 && wd_pend == 0 && fifo_q.size() == 0 && !bus0.o_busy) break;
      step(1);
    end
    chk("drain_timeout", 32'(i >= 3000), 0);
  endtask

  // FIFO model: pop after a sampled rd_en; empty/data update after the edge.
  initial forever begin
    bit p;
    @(negedge clk);
    p = bus0.o_fifo_rd_en;
    @(posedge clk);
    #2;
    if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fe = (fifo_q.size() == 0);
    fd = fe ? '0 : fifo_q[0];
  end

  // UART model: done pulse dly cycles after each start.
  initial forever begin
    @(posedge clk);
    #1;
    uart_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) uart_done = 1'b1;
    end
    if (bus0.o_tx_start) cnt = dly;
  end

  // Monitor: compare every presented byte/pop/word_done against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (bus0.o_fifo_rd_en) begin
      rd_count++;
      chk("rd_sync", 32'(bus1.o_fifo_rd_en), 1);
      chk("rd_not_empty", 32'(fe), 0);
      if (b2b_chk && b2b_seen) chk("done_to_rd", 32'(cyc - done_cyc), 2);
      if (b2b_chk) b2b_seen = 1;
      rd_cyc = cyc;
      byte_n = 0;
    end
    if (bus0.o_tx_start) begin
      chk("start_sync", 32'(bus1.o_tx_start), 1);
      if (exp0.size() == 0 || exp1.size() == 0) chk("unexpected_start", 1, 0);
      else begin
        chk("byte_lsb_first", 32'(bus0.o_tx_data), 32'(exp0.pop_front()));
        chk("byte_msb_first", 32'(bus1.o_tx_data), 32'(exp1.pop_front()));
      end
      if (byte_n == 0) chk("rd_to_start", 32'(cyc - rd_cyc), 1);
      else chk("done_to_start", 32'(cyc - done_cyc), 1);
      byte_n++;
      last0 = bus0.o_tx_data;
      last1 = bus1.o_tx_data;
    end else if (bus0.o_busy && !bus0.o_fifo_rd_en) begin
      chk("hold_lsb", 32'(bus0.o_tx_data), 32'(last0));
      chk("hold_msb", 32'(bus1.o_tx_data), 32'(last1));
    end
    if (bus0.i_tx_done) done_cyc = cyc;
    if (bus0.o_word_done) begin
      chk("wdone_sync", 32'(bus1.o_word_done), 1);
      if (wd_pend == 0) chk("unexpected_word_done", 1, 0);
      else wd_pend--;
      chk("word_bytes", 32'(byte_n), 32'(NEXP));
      chk("done_to_wdone", 32'(cyc - done_cyc), 1);
      wd_count++;
    end
  end

  initial begin
    int base;
    bit ok;
    // Reset held with FIFO non-empty: everything stays at zero.
    push_word(32'h12345678);
    repeat (3) begin
      step(1);
      chk("reset_out_lsb", {bus0.o_fifo_rd_en, bus0.o_tx_start, bus0.o_busy,
                            bus0.o_word_done, bus0.o_tx_data}, 0);
      chk("reset_out_msb", {bus1.o_fifo_rd_en, bus1.o_tx_start, bus1.o_busy,
                            bus1.o_word_done, bus1.o_tx_data}, 0);
    end
    chk("reset_no_pop", 32'(rd_count), 0);
    rst_n = 1'b1;
    drain();
    chk("single_pops", 32'(rd_count), 1);
    chk("single_wdone", 32'(wd_count), 1);

    push_word(32'hDEADBEEF);
    drain();

    // Back-to-back words: two pops, second pop 2 cycles after final done.
    base = rd_count;
    b2b_chk = 1; b2b_seen = 0;
    push_word(32'h00000001);
    push_word(32'hFFFFFFFF);
    drain();
    chk("b2b_pops", 32'(rd_count - base), 2);
    b2b_chk = 0;

    // Spurious done while idle.
    spur_done = 1'b1; step(1); spur_done = 1'b0;
    step(5);
    chk("spur_idle", 32'(bus0.o_busy | bus1.o_busy), 0);

    // Reset while waiting on byte 2.
    push_word($urandom);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (byte_n == 2 && bus0.o_busy && !bus0.o_tx_start) begin ok = 1; break; end
      step(1);
    end
    chk("reach_byte2", 32'(ok), 1);
    rst_n = 1'b0;
    step(2);
    chk("midreset_out", {bus0.o_tx_start, bus0.o_busy, bus1.o_tx_start, bus1.o_busy}, 0);
    exp0.delete(); exp1.delete(); wd_pend = 0;
    rst_n = 1'b1;
    step(20);
    chk("midreset_idle", 32'(bus0.o_busy | bus1.o_busy), 0);
    push_word(32'hCAFEF00D);
    drain();

    // Random words in bursts with random UART latency.
    for (int r = 0; r < 6; r++) begin
      dly = $urandom_range(1, 12);
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) push_word($urandom);
      drain();
    end

    chk("exp_empty", 32'(exp0.size()), 0);
    chk("wd_pend_zero", 32'(wd_pend), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
